// File: rtl/slurm16_wb_pkg.sv
// Shared definitions for the slurm16 writeback stage.
//   ld_mode_e   : load formatting modes carried in each load tag
//   ld_fmt_t    : the {mode, lane} part of a load tag (the register
//                 select is prepended by the user, its width is a parameter)
//   LD_FMT_BITS : width of ld_fmt_t
//   select_byte : picks the addressed byte lane out of a 16-bit word
package slurm16_wb_pkg;

    // Encoding 3 is reserved; the formatter treats it exactly like WORD.
    typedef enum logic [1:0] {
        LD_WORD    = 2'd0,
        LD_BYTE_ZX = 2'd1,
        LD_BYTE_SX = 2'd2,
        LD_RSVD    = 2'd3
    } ld_mode_e;

    typedef struct packed {
        ld_mode_e mode;
        logic     lane;
    } ld_fmt_t;

    localparam int LD_FMT_BITS = $bits(ld_fmt_t);

    // Full tag width for a given register-select width: {reg, mode, lane}.
    function automatic int tag_bits(input int reg_bits);
        return reg_bits + LD_FMT_BITS;
    endfunction

    // Lane 0 is the low byte, lane 1 the high byte.
    function automatic logic [7:0] select_byte(input logic [15:0] word,
                                               input logic        lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/slurm16_load_tag_fifo.sv
// In-order FIFO of outstanding load tags.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : enqueue push_data (accepted when not full, or when a pop
//                 happens in the same cycle)
//   pop         : dequeue the head (ignored when empty)
//   head_data   : current head entry, valid whenever empty = 0
//   full, empty : registered-state fill flags
//   entry_valid : one bit per storage slot, set when the slot holds a live tag
//   entry_reg   : flat view of the register field of every slot (slot i at
//                 [i*REG_BITS +: REG_BITS]) for scoreboard compares
// Tag layout: register select in the top REG_BITS bits.
module slurm16_load_tag_fifo #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 10,
    parameter int REG_BITS = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          head_data,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          entry_valid,
    output logic [DEPTH*REG_BITS-1:0] entry_reg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // A pop frees the slot the push needs, so push is legal even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide; DEPTH is a power of two so the
            // natural binary wrap is the modulo-DEPTH wrap.
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // The head is needed in the same cycle as the pop for formatting.
    assign head_data = mem[rd_ptr_reg];

    // Slot gi is live when its distance from the read pointer (mod DEPTH)
    // is below the current count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] offset;
            assign offset                             = PTR_W'(gi) - rd_ptr_reg;
            assign entry_valid[gi]                    = ({1'b0, offset} < count_reg);
            assign entry_reg[gi*REG_BITS +: REG_BITS] = mem[gi][WIDTH-1 -: REG_BITS];
        end
    endgenerate

endmodule

// File: rtl/slurm16_cpu_writeback_lq.sv
// slurm16 writeback stage with an in-order load tag queue.
// Merges variable-latency load returns and fixed-latency execute results onto
// one register-file write port (priority: load return > skid > new result),
// formats loads (word / zero- or sign-extended byte lane) and exports a
// pending-load scoreboard for hazard detection.
//   CLK, RSTb                      : clock, asynchronous active-low reset
//   res_valid/res_reg/res_data     : execute result; res_ready = 0 stalls
//   ld_issue/ld_reg/ld_mode/ld_lane: load issued to memory, tag pushed
//   ld_full                        : tag queue full
//   mem_valid/mem_data             : load data returning in issue order
//   reg_wr_en/reg_wr_sel/reg_out   : registered register-file write port
//   query_a/b, hit_a/b             : scoreboard lookups
//   err_overflow/err_underflow     : sticky protocol errors
module slurm16_cpu_writeback_lq
    import slurm16_wb_pkg::*;
#(
    parameter int REGISTER_BITS = 7,
    parameter int BITS          = 16,
    parameter int DEPTH         = 4
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     res_valid,
    input  logic [REGISTER_BITS-1:0] res_reg,
    input  logic [BITS-1:0]          res_data,
    output logic                     res_ready,
    input  logic                     ld_issue,
    input  logic [REGISTER_BITS-1:0] ld_reg,
    input  logic [1:0]               ld_mode,
    input  logic                     ld_lane,
    output logic                     ld_full,
    input  logic                     mem_valid,
    input  logic [BITS-1:0]          mem_data,
    output logic                     reg_wr_en,
    output logic [REGISTER_BITS-1:0] reg_wr_sel,
    output logic [BITS-1:0]          reg_out,
    input  logic [REGISTER_BITS-1:0] query_a,
    input  logic [REGISTER_BITS-1:0] query_b,
    output logic                     hit_a,
    output logic                     hit_b,
    output logic                     err_overflow,
    output logic                     err_underflow
);

    localparam int TAG_BITS = tag_bits(REGISTER_BITS);

    // ------------------------------------------------------------------
    // Load tag queue
    // ------------------------------------------------------------------
    logic [TAG_BITS-1:0]            push_tag;
    logic [TAG_BITS-1:0]            head_tag;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [DEPTH-1:0]               entry_valid;
    logic [DEPTH*REGISTER_BITS-1:0] entry_reg;

    assign push_tag = {ld_reg, ld_mode, ld_lane};

    slurm16_load_tag_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (TAG_BITS),
        .REG_BITS (REGISTER_BITS)
    ) u_tag_fifo (
        .clk         (CLK),
        .rst_n       (RSTb),
        .push        (ld_issue),
        .push_data   (push_tag),
        .pop         (mem_valid),
        .head_data   (head_tag),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg)
    );

    assign ld_full = fifo_full;

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [REGISTER_BITS-1:0] head_reg;
    ld_fmt_t                  head_fmt;
    logic [7:0]               lane_byte;
    logic [BITS-1:0]          load_data;
    logic                     load_fire;

    assign head_reg  = head_tag[TAG_BITS-1 -: REGISTER_BITS];
    assign head_fmt  = ld_fmt_t'(head_tag[LD_FMT_BITS-1:0]);
    assign lane_byte = select_byte(mem_data[15:0], head_fmt.lane);

    // A return with nothing outstanding is dropped (flagged as underflow).
    assign load_fire = mem_valid && !fifo_empty;

    always_comb begin
        load_data = mem_data;
        case (head_fmt.mode)
            LD_BYTE_ZX: load_data = {{(BITS-8){1'b0}}, lane_byte};
            LD_BYTE_SX: load_data = {{(BITS-8){lane_byte[7]}}, lane_byte};
            default:    load_data = mem_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Skid register and write-port arbitration
    // ------------------------------------------------------------------
    logic                     skid_valid_reg;
    logic [REGISTER_BITS-1:0] skid_reg_reg;
    logic [BITS-1:0]          skid_data_reg;

    logic                     win_valid;
    logic [REGISTER_BITS-1:0] win_reg;
    logic [BITS-1:0]          win_data;
    logic                     skid_take;
    logic                     skid_drain;

    // res_ready depends only on state, so an execute result offered while
    // the skid is empty is always accepted: it either writes directly or,
    // if a load return wins the port, parks in the skid.
    assign res_ready = !skid_valid_reg;

    always_comb begin
        win_valid  = 1'b0;
        win_reg    = '0;
        win_data   = '0;
        skid_take  = 1'b0;
        skid_drain = 1'b0;
        if (load_fire) begin
            win_valid = 1'b1;
            win_reg   = head_reg;
            win_data  = load_data;
            skid_take = res_valid && !skid_valid_reg;
        end else if (skid_valid_reg) begin
            win_valid  = 1'b1;
            win_reg    = skid_reg_reg;
            win_data   = skid_data_reg;
            skid_drain = 1'b1;
        end else if (res_valid) begin
            win_valid = 1'b1;
            win_reg   = res_reg;
            win_data  = res_data;
        end
    end

    logic                     reg_wr_en_reg;
    logic [REGISTER_BITS-1:0] reg_wr_sel_reg;
    logic [BITS-1:0]          reg_out_reg;
    logic                     err_overflow_reg;
    logic                     err_underflow_reg;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            skid_valid_reg    <= 1'b0;
            skid_reg_reg      <= '0;
            skid_data_reg     <= '0;
            reg_wr_en_reg     <= 1'b0;
            reg_wr_sel_reg    <= '0;
            reg_out_reg       <= '0;
            err_overflow_reg  <= 1'b0;
            err_underflow_reg <= 1'b0;
        end else begin
            if (skid_take) begin
                skid_valid_reg <= 1'b1;
                skid_reg_reg   <= res_reg;
                skid_data_reg  <= res_data;
            end else if (skid_drain) begin
                skid_valid_reg <= 1'b0;
            end

            // Register 0 is hard-wired: the slot is consumed, the strobe is not.
            reg_wr_en_reg <= win_valid && (win_reg != '0);
            if (win_valid) begin
                reg_wr_sel_reg <= win_reg;
                reg_out_reg    <= win_data;
            end

            // A full queue with a same-cycle return is never an overflow,
            // since that return frees the slot the new tag needs.
            if (ld_issue && fifo_full && !mem_valid) begin
                err_overflow_reg <= 1'b1;
            end
            if (mem_valid && fifo_empty) begin
                err_underflow_reg <= 1'b1;
            end
        end
    end

    assign reg_wr_en     = reg_wr_en_reg;
    assign reg_wr_sel    = reg_wr_sel_reg;
    assign reg_out       = reg_out_reg;
    assign err_overflow  = err_overflow_reg;
    assign err_underflow = err_underflow_reg;

    // ------------------------------------------------------------------
    // Pending-load scoreboard: registered queue state only, so a tag pushed
    // this cycle is not yet visible while the head being popped still is.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_a[gi] = entry_valid[gi] &&
                                 (entry_reg[gi*REGISTER_BITS +: REGISTER_BITS] == query_a);
            assign match_b[gi] = entry_valid[gi] &&
                                 (entry_reg[gi*REGISTER_BITS +: REGISTER_BITS] == query_b);
        end
    endgenerate

    assign hit_a = (query_a != '0) && (|match_a);
    assign hit_b = (query_b != '0) && (|match_b);

endmodule

// File: tb/tb_slurm16_cpu_writeback_lq.sv
// Self-checking bench for slurm16_cpu_writeback_lq: directed vector table,
// hand-written multi-cycle sequences and a randomized run, all compared
// against a queue-based reference model of the writeback rules.
module tb_slurm16_cpu_writeback_lq;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        res_valid;
    logic [6:0]  res_reg;
    logic [15:0] res_data;
    logic        res_ready;
    logic        ld_issue;
    logic [6:0]  ld_reg;
    logic [1:0]  ld_mode;
    logic        ld_lane;
    logic        ld_full;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        reg_wr_en;
    logic [6:0]  reg_wr_sel;
    logic [15:0] reg_out;
    logic [6:0]  query_a;
    logic [6:0]  query_b;
    logic        hit_a;
    logic        hit_b;
    logic        err_overflow;
    logic        err_underflow;

    slurm16_cpu_writeback_lq #(
        .REGISTER_BITS (7),
        .BITS          (16),
        .DEPTH         (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RSTb          (RSTb),
        .res_valid     (res_valid),
        .res_reg       (res_reg),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .ld_issue      (ld_issue),
        .ld_reg        (ld_reg),
        .ld_mode       (ld_mode),
        .ld_lane       (ld_lane),
        .ld_full       (ld_full),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_sel    (reg_wr_sel),
        .reg_out       (reg_out),
        .query_a       (query_a),
        .query_b       (query_b),
        .hit_a         (hit_a),
        .hit_b         (hit_b),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [6:0] r;
        logic [1:0] m;
        logic       l;
    } tag_t;

    tag_t        mq[$];
    bit          m_skid_v;
    logic [6:0]  m_skid_r;
    logic [15:0] m_skid_d;
    bit          m_of;
    bit          m_uf;
    bit          e_en;
    logic [6:0]  e_sel;
    logic [15:0] e_out;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [15:0] fmt_load(input tag_t t, input logic [15:0] d);
        int b;
        b = (int'(d) >> (8 * int'(t.l))) & 255;
        if (t.m == 2'd1) return 16'(b);
        if (t.m == 2'd2) return (b >= 128) ? 16'(b + 'hFF00) : 16'(b);
        return d;
    endfunction

    function automatic bit m_hit(input logic [6:0] q);
        if (q == 7'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].r == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input bit rv, input logic [6:0] rr, input logic [15:0] rd,
                         input bit li, input logic [6:0] lr, input logic [1:0] lm, input bit ll,
                         input bit mv, input logic [15:0] md,
                         input logic [6:0] qa, input logic [6:0] qb);
        res_valid = rv; res_reg = rr; res_data = rd;
        ld_issue = li; ld_reg = lr; ld_mode = lm; ld_lane = ll;
        mem_valid = mv; mem_data = md;
        query_a = qa; query_b = qb;
    endtask

    task automatic idle(input logic [6:0] qa, input logic [6:0] qb);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, qa, qb);
    endtask

    // One clock cycle with the inputs currently driven. Entered and left
    // 1 time unit after a rising edge.
    task automatic step();
        bit   pop_ok;
        bit   push_ok;
        tag_t t;
        #1;
        chk("res_ready", res_ready, !m_skid_v);
        chk("ld_full", ld_full, mq.size() == DEPTH);
        chk("hit_a", hit_a, m_hit(query_a));
        chk("hit_b", hit_b, m_hit(query_b));
        chk("err_overflow", err_overflow, m_of);
        chk("err_underflow", err_underflow, m_uf);

        pop_ok  = mem_valid && (mq.size() > 0);
        push_ok = ld_issue && ((mq.size() < DEPTH) || pop_ok);
        if (mem_valid && mq.size() == 0) m_uf = 1'b1;
        if (ld_issue && !push_ok) m_of = 1'b1;
        e_en = 1'b0;
        if (pop_ok) begin
            t     = mq.pop_front();
            e_sel = t.r;
            e_out = fmt_load(t, mem_data);
            e_en  = (t.r != 0);
            if (!m_skid_v && res_valid) begin
                m_skid_v = 1'b1; m_skid_r = res_reg; m_skid_d = res_data;
            end
        end else if (m_skid_v) begin
            e_sel = m_skid_r; e_out = m_skid_d; e_en = (m_skid_r != 0);
            m_skid_v = 1'b0;
        end else if (res_valid) begin
            e_sel = res_reg; e_out = res_data; e_en = (res_reg != 0);
        end
        if (push_ok) begin
            t.r = ld_reg; t.m = ld_mode; t.l = ld_lane;
            mq.push_back(t);
        end

        @(posedge CLK);
        #1;
        chk("reg_wr_en", reg_wr_en, e_en);
        if (e_en) begin
            chk("reg_wr_sel", reg_wr_sel, e_sel);
            chk("reg_out", reg_out, e_out);
        end
    endtask

    task automatic check_reset_values(input string tagname);
        chk({tagname, "_wr_en"}, reg_wr_en, 0);
        chk({tagname, "_wr_sel"}, reg_wr_sel, 0);
        chk({tagname, "_out"}, reg_out, 0);
        chk({tagname, "_ld_full"}, ld_full, 0);
        chk({tagname, "_res_ready"}, res_ready, 1);
        chk({tagname, "_hit_a"}, hit_a, 0);
        chk({tagname, "_hit_b"}, hit_b, 0);
        chk({tagname, "_err_of"}, err_overflow, 0);
        chk({tagname, "_err_uf"}, err_underflow, 0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_skid_v = 1'b0; m_of = 1'b0; m_uf = 1'b0; e_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          rv;
        logic [6:0]  rr;
        logic [15:0] rd;
        bit          li;
        logic [6:0]  lr;
        logic [1:0]  lm;
        bit          ll;
        bit          mv;
        logic [15:0] md;
        bit          x_en;
        logic [6:0]  x_sel;
        logic [15:0] x_out;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(0, 0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("por");
        @(negedge CLK);
        RSTb = 1'b1;
        @(posedge CLK);
        #1;

        //          rv rr    rd        li lr   lm  ll mv md        en sel  out
        vt[0] = '{1, 7'd5, 16'h1234, 0, 7'd0, 2'd0, 0, 0, 16'h0000, 1, 7'd5, 16'h1234};
        vt[1] = '{0, 7'd0, 16'h0000, 1, 7'd3, 2'd2, 1, 0, 16'h0000, 0, 7'd0, 16'h0000};
        vt[2] = '{0, 7'd0, 16'h0000, 0, 7'd0, 2'd0, 0, 1, 16'h80AA, 1, 7'd3, 16'hFF80};
        vt[3] = '{0, 7'd0, 16'h0000, 1, 7'd3, 2'd1, 0, 0, 16'h0000, 0, 7'd0, 16'h0000};
        vt[4] = '{0, 7'd0, 16'h0000, 0, 7'd0, 2'd0, 0, 1, 16'h80AA, 1, 7'd3, 16'h00AA};
        vt[5] = '{0, 7'd0, 16'h0000, 1, 7'd3, 2'd0, 1, 0, 16'h0000, 0, 7'd0, 16'h0000};
        vt[6] = '{0, 7'd0, 16'h0000, 0, 7'd0, 2'd0, 0, 1, 16'h80AA, 1, 7'd3, 16'h80AA};
        vt[7] = '{1, 7'd0, 16'h5555, 0, 7'd0, 2'd0, 0, 0, 16'h0000, 0, 7'd0, 16'h0000};

        for (int i = 0; i < 8; i++) begin
            drive(vt[i].rv, vt[i].rr, vt[i].rd, vt[i].li, vt[i].lr, vt[i].lm, vt[i].ll,
                  vt[i].mv, vt[i].md, 0, 0);
            step();
            chk($sformatf("vec%0d_en", i), reg_wr_en, vt[i].x_en);
            if (vt[i].x_en) begin
                chk($sformatf("vec%0d_sel", i), reg_wr_sel, vt[i].x_sel);
                chk($sformatf("vec%0d_out", i), reg_out, vt[i].x_out);
            end
            $display("vec %0d: wr_en=%0d sel=%0d out=%h", i, reg_wr_en, reg_wr_sel, reg_out);
        end

        // Load return and execute result colliding: load first, result parked.
        drive(0, 0, 0, 1, 7'd2, 2'd0, 0, 0, 0, 0, 0);
        step();
        drive(1, 7'd7, 16'h7777, 0, 0, 0, 0, 1, 16'h1111, 0, 0);
        step();
        chk("collide_first_sel", reg_wr_sel, 7'd2);
        chk("collide_ready_low", res_ready, 0);
        $display("collide: first sel=%0d out=%h", reg_wr_sel, reg_out);
        drive(1, 7'd8, 16'h8888, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("collide_second_sel", reg_wr_sel, 7'd7);
        chk("collide_second_out", reg_out, 16'h7777);
        $display("collide: second sel=%0d out=%h", reg_wr_sel, reg_out);
        idle(0, 0);
        step();

        // Fill, push+pop while full, then overflow.
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 0, 0, 1, 7'(i), 2'd0, 0, 0, 0, 0, 0);
            step();
        end
        idle(0, 0);
        #1;
        chk("full_after_fill", ld_full, 1);
        drive(0, 0, 0, 1, 7'd5, 2'd0, 0, 1, 16'hA001, 0, 0);
        step();
        chk("full_after_pushpop", ld_full, 1);
        chk("no_overflow_pushpop", err_overflow, 0);
        drive(0, 0, 0, 1, 7'd6, 2'd0, 0, 0, 0, 0, 0);
        step();
        chk("overflow_set", err_overflow, 1);
        $display("overflow: full=%0d err_overflow=%0d", ld_full, err_overflow);
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 16'(16'hB000 + i), 0, 0);
            step();
            $display("drain %0d: sel=%0d out=%h", i, reg_wr_sel, reg_out);
        end
        chk("drain_last_sel", reg_wr_sel, 7'd5);
        chk("drain_empty_full", ld_full, 0);

        // Scoreboard with r4 and r9 pending.
        drive(0, 0, 0, 1, 7'd4, 2'd0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 1, 7'd9, 2'd0, 0, 0, 0, 0, 0);
        step();
        idle(7'd9, 7'd0);
        #1;
        chk("sb_hit_a_r9", hit_a, 1);
        chk("sb_hit_b_r0", hit_b, 0);
        $display("scoreboard: hit_a=%0d hit_b=%0d", hit_a, hit_b);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h0404, 7'd9, 7'd4);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h0909, 7'd9, 7'd4);
        step();
        idle(7'd9, 7'd4);
        #1;
        chk("sb_clear_a", hit_a, 0);
        chk("sb_clear_b", hit_b, 0);

        // Underflow on an empty queue.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD, 0, 0);
        step();
        chk("underflow_no_write", reg_wr_en, 0);
        chk("underflow_set", err_underflow, 1);
        $display("underflow: err_underflow=%0d", err_underflow);

        // Reset mid-queue, with a parked skid result too.
        drive(0, 0, 0, 1, 7'd4, 2'd0, 0, 0, 0, 0, 0);
        step();
        drive(1, 7'd11, 16'h0B0B, 1, 7'd5, 2'd0, 0, 1, 16'h4444, 0, 0);
        step();
        idle(7'd5, 7'd5);
        #2;
        RSTb = 1'b0;
        model_reset();
        #2;
        check_reset_values("midrst");
        $display("mid reset: wr_en=%0d full=%0d ready=%0d", reg_wr_en, ld_full, res_ready);
        @(negedge CLK);
        RSTb = 1'b1;
        @(posedge CLK);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 16'h5555, 7'd5, 0);
        step();
        chk("post_reset_underflow", err_underflow, 1);
        chk("post_reset_no_write", reg_wr_en, 0);

        // Randomized run.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), 7'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 2) != 0), 7'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), 16'($urandom),
                  7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)));
            step();
            $display("rnd %0d: wr_en=%0d sel=%0d out=%h depth=%0d", i, reg_wr_en, reg_wr_sel,
                     reg_out, mq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
